// File: rtl/icache_loader.sv
// rtl/icache_loader.sv - byte-stream loader that fills a 16-bit instruction cache
//
// Purpose:
//   Accepts a little-endian byte stream: a 16-bit halfword count N, then N halfwords.
//   Each halfword is written to cache cell base_index + k (k = 0..N-1).
//   A load whose cells would not fit in DEPTH sets a sticky error and performs no writes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_index        load request (honoured only when idle) and first cell index
//   in_byte, in_valid        incoming stream byte and its valid qualifier
//   in_ready                 loader can take a byte this cycle
//   write_enable             one-cycle write strobe per halfword
//   write_instruction_index  target cell of the write
//   write_instruction        halfword being written
//   busy, done, error        status: not idle / completion pulse / sticky length error
module icache_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_index,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        write_enable,
  output logic [31:0] write_instruction_index,
  output logic [15:0] write_instruction,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    FINISH
  } state_t;

  localparam logic [32:0] DEPTH33 = 33'(DEPTH);

  state_t      state;
  state_t      state_next;
  logic [31:0] base_q;
  logic [7:0]  len_lo_q;
  logic [15:0] count_q;
  logic [15:0] k_q;
  logic [7:0]  low_q;

  logic        xfer;
  logic [15:0] len_full;
  logic [32:0] end_index;
  logic        len_bad;
  logic [16:0] k_inc;
  logic        more;

  assign in_ready     = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA_LO) || (state == DATA_HI);
  assign write_enable = (state == WRITE);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign xfer         = in_valid & in_ready;

  // Count as it will be once the high byte lands; the range check is 33 bits wide
  // so a base near 2^32 cannot wrap around and pass.
  assign len_full  = {in_byte, len_lo_q};
  assign end_index = {1'b0, base_q} + {17'b0, len_full};
  assign len_bad   = ({17'b0, len_full} > DEPTH33) || (end_index > DEPTH33);

  assign k_inc = {1'b0, k_q} + 17'd1;
  assign more  = k_inc < {1'b0, count_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LEN_LO;
      LEN_LO:  if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0) state_next = FINISH;
          else if (len_bad)      state_next = IDLE;
          else                   state_next = DATA_LO;
        end
      end
      DATA_LO: if (xfer) state_next = DATA_HI;
      DATA_HI: if (xfer) state_next = WRITE;
      WRITE:   state_next = more ? DATA_LO : FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q                  <= '0;
      len_lo_q                <= '0;
      count_q                 <= '0;
      k_q                     <= '0;
      low_q                   <= '0;
      write_instruction_index <= '0;
      write_instruction       <= '0;
      error                   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_index;
            k_q    <= '0;
            error  <= 1'b0;
          end
        end
        LEN_LO: begin
          if (xfer) len_lo_q <= in_byte;
        end
        LEN_HI: begin
          if (xfer) begin
            count_q <= len_full;
            k_q     <= '0;
            if ((len_full != 16'd0) && len_bad) error <= 1'b1;
          end
        end
        DATA_LO: begin
          if (xfer) low_q <= in_byte;
        end
        DATA_HI: begin
          if (xfer) begin
            write_instruction       <= {in_byte, low_q};
            write_instruction_index <= base_q + {16'b0, k_q};
          end
        end
        WRITE: begin
          k_q <= k_inc[15:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_loader.sv
// tb/tb_icache_loader.sv - directed self-checking bench for icache_loader
module tb_icache_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_index;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        write_enable;
  logic [31:0] write_instruction_index;
  logic [15:0] write_instruction;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_idx[$];
  logic [15:0] wr_dat[$];
  int          done_cnt = 0;

  icache_loader #(.DEPTH(256)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_index(base_index),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .write_enable(write_enable),
    .write_instruction_index(write_instruction_index),
    .write_instruction(write_instruction),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) begin
      wr_idx.push_back(write_instruction_index);
      wr_dat.push_back(write_instruction);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b);
    base_index = b;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("idle_timeout", 32'd1, 32'd0);
    tick();
  endtask

  int wb;
  int db;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_index = 32'd0;
    in_byte    = 8'h00;
    in_valid   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_idx", write_instruction_index, 32'd0);
    chk("rst_instr", 32'(write_instruction), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // basic three-halfword load, back-to-back bytes
    wb = wr_idx.size(); db = done_cnt;
    do_start(32'd10);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);
    send(8'h03, 0); send(8'h00, 0);
    send(8'h34, 0); send(8'h12, 0);
    chk("t1_latency_we", 32'(write_enable), 32'd1);
    chk("t1_latency_idx", write_instruction_index, 32'd10);
    chk("t1_latency_dat", 32'(write_instruction), 32'h1234);
    chk("t1_write_ready", 32'(in_ready), 32'd0);
    send(8'h78, 0); send(8'h56, 0);
    send(8'hBC, 0); send(8'h9A, 0);
    wait_idle();
    chk("t1_nwr", 32'(wr_idx.size() - wb), 32'd3);
    chk("t1_i0", wr_idx[wb], 32'd10);
    chk("t1_d0", 32'(wr_dat[wb]), 32'h1234);
    chk("t1_i1", wr_idx[wb+1], 32'd11);
    chk("t1_d1", 32'(wr_dat[wb+1]), 32'h5678);
    chk("t1_i2", wr_idx[wb+2], 32'd12);
    chk("t1_d2", 32'(wr_dat[wb+2]), 32'h9ABC);
    chk("t1_done", 32'(done_cnt - db), 32'd1);
    chk("t1_error", 32'(error), 32'd0);

    // same stream with two idle cycles before every byte
    wb = wr_idx.size(); db = done_cnt;
    do_start(32'd10);
    send(8'h03, 2); send(8'h00, 2);
    send(8'h34, 2);
    in_valid = 1'b0;
    tick(); tick();
    chk("t2_hold_ready", 32'(in_ready), 32'd1);
    chk("t2_hold_we", 32'(write_enable), 32'd0);
    send(8'h12, 0);
    send(8'h78, 2); send(8'h56, 2);
    send(8'hBC, 2); send(8'h9A, 2);
    wait_idle();
    chk("t2_nwr", 32'(wr_idx.size() - wb), 32'd3);
    chk("t2_i1", wr_idx[wb+1], 32'd11);
    chk("t2_d2", 32'(wr_dat[wb+2]), 32'h9ABC);
    chk("t2_done", 32'(done_cnt - db), 32'd1);

    // zero-length load: done three cycles after start
    wb = wr_idx.size(); db = done_cnt;
    do_start(32'd0);
    send(8'h00, 0); send(8'h00, 0);
    chk("t3_done_pulse", 32'(done), 32'd1);
    tick();
    chk("t3_done_low", 32'(done), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_nwr", 32'(wr_idx.size() - wb), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt - db), 32'd1);

    // range error: 250 + 7 > 256
    wb = wr_idx.size(); db = done_cnt;
    do_start(32'd250);
    send(8'h07, 0); send(8'h00, 0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t4_nwr", 32'(wr_idx.size() - wb), 32'd0);
    chk("t4_nodone", 32'(done_cnt - db), 32'd0);
    do_start(32'd255);
    chk("t4_err_cleared", 32'(error), 32'd0);
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0);
    wait_idle();
    chk("t4_edge_nwr", 32'(wr_idx.size() - wb), 32'd1);
    chk("t4_edge_idx", wr_idx[wb], 32'd255);
    chk("t4_edge_dat", 32'(wr_dat[wb]), 32'hBEEF);
    chk("t4_edge_err", 32'(error), 32'd0);

    // 255 + 2 overflows the cache by one
    do_start(32'd255);
    send(8'h02, 0); send(8'h00, 0);
    chk("t4_over1_err", 32'(error), 32'd1);
    // count alone exceeds DEPTH
    do_start(32'd0);
    send(8'h01, 0); send(8'h01, 0);
    chk("t4_n257_err", 32'(error), 32'd1);
    // base + N would wrap in 32 bits
    do_start(32'hFFFF_FFFF);
    send(8'h01, 0); send(8'h00, 0);
    chk("t4_wrap_err", 32'(error), 32'd1);
    tick();
    chk("t4_err_nwr", 32'(wr_idx.size() - wb), 32'd1);

    // reset after the second halfword's low byte
    wb = wr_idx.size();
    do_start(32'd20);
    send(8'h03, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0);
    send(8'h33, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_we", 32'(write_enable), 32'd0);
    chk("t5_idx", write_instruction_index, 32'd0);
    chk("t5_instr", 32'(write_instruction), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_error", 32'(error), 32'd0);
    in_byte  = 8'h44;
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("t5_nwr", 32'(wr_idx.size() - wb), 32'd1);
    chk("t5_i0", wr_idx[wb], 32'd20);
    chk("t5_d0", 32'(wr_dat[wb]), 32'h2211);
    do_start(32'd5);
    send(8'h01, 0); send(8'h00, 0);
    send(8'h44, 0); send(8'h55, 0);
    wait_idle();
    chk("t5_after_nwr", 32'(wr_idx.size() - wb), 32'd2);
    chk("t5_after_idx", wr_idx[wb+1], 32'd5);
    chk("t5_after_dat", 32'(wr_dat[wb+1]), 32'h5544);

    // start during DATA_LO is ignored
    wb = wr_idx.size(); db = done_cnt;
    do_start(32'd30);
    send(8'h02, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0);
    tick();
    do_start(32'd99);
    base_index = 32'd0;
    send(8'h03, 0); send(8'h04, 0);
    wait_idle();
    chk("t6_nwr", 32'(wr_idx.size() - wb), 32'd2);
    chk("t6_i0", wr_idx[wb], 32'd30);
    chk("t6_d0", 32'(wr_dat[wb]), 32'h0201);
    chk("t6_i1", wr_idx[wb+1], 32'd31);
    chk("t6_d1", 32'(wr_dat[wb+1]), 32'h0403);
    chk("t6_done", 32'(done_cnt - db), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_loader.md
ICACHE_LOADER -- requirements
Module: icache_loader

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit cells in the instruction cache being filled.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-005 base_index  input  32  first cache cell index; sampled on accepted start.
REQ-006 in_byte  input  8  incoming stream byte.
REQ-007 in_valid  input  1  in_byte is valid this cycle.
REQ-008 in_ready  output  1  loader accepts in_byte this cycle; transfer = in_valid & in_ready.
REQ-009 write_enable  output  1  write strobe to instruction cache, one cycle per halfword.
REQ-010 write_instruction_index  output  32  target cell index for the current write.
REQ-011 write_instruction  output  16  halfword being written.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful load completion.
REQ-014 error  output  1  sticky length-error flag; cleared by rst or accepted start.

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, FINISH.
REQ-016 IDLE -> LEN_LO on start; start ignored in all other states.
REQ-017 Stream format, little-endian: count N (16 bit, LO then HI byte), then N halfwords, each LO byte then HI byte.
REQ-018 in_ready = 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI; 0 in IDLE, WRITE, FINISH.
REQ-019 A state consuming a byte advances only on a transfer; in_valid=0 holds state, no timeout.
REQ-020 LEN_HI transfer: N=0 -> FINISH; N>DEPTH or base_index+N>DEPTH -> set error, -> IDLE, no writes; else -> DATA_LO with halfword counter k=0.
REQ-021 DATA_LO transfer: latch low byte -> DATA_HI.
REQ-022 DATA_HI transfer: -> WRITE; write_instruction = {in_byte, low byte}, write_instruction_index = base_index + k, both registered.
REQ-023 WRITE lasts exactly one cycle with write_enable=1; then k increments, -> DATA_LO if k+1<N, else -> FINISH.
REQ-024 Write latency: write_enable asserted on the cycle immediately after the high-byte transfer.
REQ-025 FINISH lasts one cycle with done=1, then -> IDLE.
REQ-026 write_enable=0 in every state except WRITE; index/instruction hold last values otherwise.
REQ-027 Index arithmetic is 32-bit unsigned; range check in REQ-020 computed without overflow (33-bit compare).
REQ-028 Sustained throughput: one halfword per 3 cycles with in_valid held high.

Reset
REQ-029 rst has priority over all inputs, including in-progress load; next state IDLE.
REQ-030 Reset values: in_ready=0, write_enable=0, write_instruction_index=0, write_instruction=0, busy=0, done=0, error=0, k=0.
REQ-031 Reset mid-load performs no further writes; cells already written are not reverted.

Verification
REQ-032 base_index=10, start, bytes 03 00 | 34 12 | 78 56 | BC 9A -> writes (10,0x1234),(11,0x5678),(12,0x9ABC), one done pulse, error=0.
REQ-033 Same stream with in_valid low 2 cycles between every byte -> identical writes, no extra write_enable, state held.
REQ-034 base_index=0, count bytes 00 00 -> zero writes, done pulse 3 cycles after start, returns IDLE.
REQ-035 DEPTH=256, base_index=250, count 07 00 -> error=1, no writes, busy=0 next cycle; next start clears error.
REQ-036 rst asserted for one cycle after second data halfword's low byte -> only index base written once, all outputs at reset values next cycle, subsequent load works.
REQ-037 start pulsed during DATA_LO of an active load -> ignored; load completes unchanged.
